// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and a
// req/ack freeze for variable-latency data memory, plus stall counter and timeout flag.
module hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RegRt_i,
    input  logic [4:0]       IFID_RegRs_i,
    input  logic [4:0]       IFID_RegRt_i,
    input  logic             EXMEM_Branch_i,
    input  logic             EXMEM_ALUzero_i,
    input  logic             EXMEM_MemRead_i,
    input  logic             EXMEM_MemWrite_i,
    input  logic             mem_ack_i,
    output logic             PCWrite_o,
    output logic             PCSrc_o,
    output logic             IFIDWrite_o,
    output logic             IFIDFlush_o,
    output logic             IDEXWrite_o,
    output logic             IDEXFlush_o,
    output logic             EXMEMWrite_o,
    output logic             EXMEMFlush_o,
    output logic             MEMWBBubble_o,
    output logic             mem_req_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             err_o
);

    localparam int WCNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              err_q, err_d;

    logic memop;
    logic branch_taken;
    logic load_use;
    logic freeze;
    logic lu_stall;
    logic br_flush;
    logic req;

    assign memop        = EXMEM_MemRead_i | EXMEM_MemWrite_i;
    assign branch_taken = EXMEM_Branch_i & EXMEM_ALUzero_i;
    assign load_use     = IDEX_MemRead_i && (IDEX_RegRt_i != 5'd0) &&
                          ((IDEX_RegRt_i == IFID_RegRs_i) || (IDEX_RegRt_i == IFID_RegRt_i));

    // Sequencing decisions and next-state logic.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        err_d       = err_q;
        stall_cnt_d = stall_cnt_q;
        freeze      = 1'b0;
        lu_stall    = 1'b0;
        br_flush    = 1'b0;
        req         = 1'b0;

        case (state_q)
            RUN: begin
                if (memop) begin
                    req = 1'b1;
                    if (!mem_ack_i) begin
                        freeze  = 1'b1;
                        state_d = WAIT;
                        wcnt_d  = WCNT_W'(1);
                    end
                end
                // Hazards under a freeze are dropped; held registers re-present them later.
                if (!freeze) begin
                    if (branch_taken) begin
                        br_flush = 1'b1;
                    end else if (load_use) begin
                        lu_stall = 1'b1;
                    end
                end
            end
            default: begin
                req = 1'b1;
                if (mem_ack_i) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q == WCNT_W'(TIMEOUT)) begin
                    req     = 1'b0;
                    err_d   = 1'b1;
                    state_d = RUN;
                    wcnt_d  = '0;
                end else begin
                    freeze = 1'b1;
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
        endcase

        if ((freeze || lu_stall) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Pipeline-register controls; reset forces the pass-through defaults.
    always_comb begin
        PCWrite_o     = 1'b1;
        PCSrc_o       = 1'b0;
        IFIDWrite_o   = 1'b1;
        IFIDFlush_o   = 1'b0;
        IDEXWrite_o   = 1'b1;
        IDEXFlush_o   = 1'b0;
        EXMEMWrite_o  = 1'b1;
        EXMEMFlush_o  = 1'b0;
        MEMWBBubble_o = 1'b0;
        mem_req_o     = 1'b0;

        if (!rst_i) begin
            mem_req_o = req;
            if (freeze) begin
                PCWrite_o     = 1'b0;
                IFIDWrite_o   = 1'b0;
                IDEXWrite_o   = 1'b0;
                EXMEMWrite_o  = 1'b0;
                MEMWBBubble_o = 1'b1;
            end else if (br_flush) begin
                PCSrc_o      = 1'b1;
                IFIDFlush_o  = 1'b1;
                IDEXFlush_o  = 1'b1;
                EXMEMFlush_o = 1'b1;
            end else if (lu_stall) begin
                PCWrite_o   = 1'b0;
                IFIDWrite_o = 1'b0;
                IDEXFlush_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst_i) begin
            state_q     <= RUN;
            wcnt_q      <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: control vector and counters checked against
// hand-computed values, with a small counter width so saturation is reachable.
module tb_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    // Control vector order: PCWrite PCSrc IFIDWrite IFIDFlush IDEXWrite IDEXFlush
    //                       EXMEMWrite EXMEMFlush MEMWBBubble mem_req
    localparam logic [9:0] C_DEF = 10'b1010101000;
    localparam logic [9:0] C_LU  = 10'b0000111000;
    localparam logic [9:0] C_BR  = 10'b1111111100;
    localparam logic [9:0] C_FRZ = 10'b0000000011;
    localparam logic [9:0] C_REQ = 10'b1010101001;
    localparam logic [9:0] C_BRQ = 10'b1111111101;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             IDEX_MemRead_i;
    logic [4:0]       IDEX_RegRt_i;
    logic [4:0]       IFID_RegRs_i;
    logic [4:0]       IFID_RegRt_i;
    logic             EXMEM_Branch_i;
    logic             EXMEM_ALUzero_i;
    logic             EXMEM_MemRead_i;
    logic             EXMEM_MemWrite_i;
    logic             mem_ack_i;
    logic             PCWrite_o;
    logic             PCSrc_o;
    logic             IFIDWrite_o;
    logic             IFIDFlush_o;
    logic             IDEXWrite_o;
    logic             IDEXFlush_o;
    logic             EXMEMWrite_o;
    logic             EXMEMFlush_o;
    logic             MEMWBBubble_o;
    logic             mem_req_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic             err_o;

    int n_checks = 0;
    int n_errors = 0;

    hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .IDEX_MemRead_i  (IDEX_MemRead_i),
        .IDEX_RegRt_i    (IDEX_RegRt_i),
        .IFID_RegRs_i    (IFID_RegRs_i),
        .IFID_RegRt_i    (IFID_RegRt_i),
        .EXMEM_Branch_i  (EXMEM_Branch_i),
        .EXMEM_ALUzero_i (EXMEM_ALUzero_i),
        .EXMEM_MemRead_i (EXMEM_MemRead_i),
        .EXMEM_MemWrite_i(EXMEM_MemWrite_i),
        .mem_ack_i       (mem_ack_i),
        .PCWrite_o       (PCWrite_o),
        .PCSrc_o         (PCSrc_o),
        .IFIDWrite_o     (IFIDWrite_o),
        .IFIDFlush_o     (IFIDFlush_o),
        .IDEXWrite_o     (IDEXWrite_o),
        .IDEXFlush_o     (IDEXFlush_o),
        .EXMEMWrite_o    (EXMEMWrite_o),
        .EXMEMFlush_o    (EXMEMFlush_o),
        .MEMWBBubble_o   (MEMWBBubble_o),
        .mem_req_o       (mem_req_o),
        .stall_cnt_o     (stall_cnt_o),
        .err_o           (err_o)
    );

    always #5 clk_i = ~clk_i;

    logic [9:0] ctl;
    assign ctl = {PCWrite_o, PCSrc_o, IFIDWrite_o, IFIDFlush_o, IDEXWrite_o, IDEXFlush_o,
                  EXMEMWrite_o, EXMEMFlush_o, MEMWBBubble_o, mem_req_o};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        IDEX_MemRead_i   = 1'b0;
        IDEX_RegRt_i     = 5'd0;
        IFID_RegRs_i     = 5'd0;
        IFID_RegRt_i     = 5'd0;
        EXMEM_Branch_i   = 1'b0;
        EXMEM_ALUzero_i  = 1'b0;
        EXMEM_MemRead_i  = 1'b0;
        EXMEM_MemWrite_i = 1'b0;
        mem_ack_i        = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rt, input logic [4:0] rs_f, input logic [4:0] rt_f);
        IDEX_MemRead_i = 1'b1;
        IDEX_RegRt_i   = rt;
        IFID_RegRs_i   = rs_f;
        IFID_RegRt_i   = rt_f;
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        tick();
        #1 check("reset_ctl", 32'(ctl), 32'(C_DEF));
        tick();
        rst_i = 1'b0;
        #1;
        check("reset_ctl_after", 32'(ctl), 32'(C_DEF));
        check("reset_stall", 32'(stall_cnt_o), 0);
        check("reset_err", 32'(err_o), 0);

        // Load-use on rs, then on rt
        set_lu(5'd8, 5'd8, 5'd3);
        #1 check("lu_rs_ctl", 32'(ctl), 32'(C_LU));
        tick();
        idle();
        #1 check("lu_release", 32'(ctl), 32'(C_DEF));
        check("lu_cnt1", 32'(stall_cnt_o), 1);
        set_lu(5'd8, 5'd4, 5'd8);
        #1 check("lu_rt_ctl", 32'(ctl), 32'(C_LU));
        tick();
        check("lu_cnt2", 32'(stall_cnt_o), 2);

        // Suppressed load-use: $zero destination, no match, not a load
        set_lu(5'd0, 5'd0, 5'd0);
        #1 check("lu_zero_reg", 32'(ctl), 32'(C_DEF));
        set_lu(5'd8, 5'd9, 5'd10);
        #1 check("lu_no_match", 32'(ctl), 32'(C_DEF));
        set_lu(5'd8, 5'd8, 5'd8);
        IDEX_MemRead_i = 1'b0;
        #1 check("lu_not_load", 32'(ctl), 32'(C_DEF));
        tick();
        idle();
        #1 check("lu_supp_cnt", 32'(stall_cnt_o), 2);

        // Zero-wait access and stray ack
        EXMEM_MemRead_i = 1'b1;
        mem_ack_i       = 1'b1;
        #1 check("zw_ctl", 32'(ctl), 32'(C_REQ));
        tick();
        EXMEM_MemRead_i = 1'b0;
        #1 check("stray_ack_ctl", 32'(ctl), 32'(C_DEF));
        tick();
        idle();
        #1 check("zw_ctl_after", 32'(ctl), 32'(C_DEF));
        check("zw_cnt", 32'(stall_cnt_o), 2);

        // 3-cycle write; hazards presented during the freeze are ignored
        EXMEM_MemWrite_i = 1'b1;
        #1 check("w3_c0", 32'(ctl), 32'(C_FRZ));
        tick();
        set_lu(5'd8, 5'd8, 5'd0);
        EXMEM_Branch_i  = 1'b1;
        EXMEM_ALUzero_i = 1'b1;
        #1 check("w3_c1_hazards", 32'(ctl), 32'(C_FRZ));
        tick();
        EXMEM_Branch_i  = 1'b0;
        EXMEM_ALUzero_i = 1'b0;
        #1 check("w3_c2", 32'(ctl), 32'(C_FRZ));
        tick();
        mem_ack_i = 1'b1;
        #1 check("w3_ack", 32'(ctl), 32'(C_REQ));
        tick();
        mem_ack_i        = 1'b0;
        EXMEM_MemWrite_i = 1'b0;
        #1 check("w3_lu_after", 32'(ctl), 32'(C_LU));
        check("w3_cnt", 32'(stall_cnt_o), 5);
        tick();
        idle();
        #1 check("w3_lu_cnt", 32'(stall_cnt_o), 6);

        // Branch taken / not taken and priorities
        EXMEM_Branch_i  = 1'b1;
        EXMEM_ALUzero_i = 1'b1;
        #1 check("br_taken", 32'(ctl), 32'(C_BR));
        EXMEM_ALUzero_i = 1'b0;
        #1 check("br_not_taken", 32'(ctl), 32'(C_DEF));
        EXMEM_ALUzero_i = 1'b1;
        set_lu(5'd7, 5'd7, 5'd0);
        #1 check("br_over_lu", 32'(ctl), 32'(C_BR));
        EXMEM_MemRead_i = 1'b1;
        mem_ack_i       = 1'b1;
        #1 check("br_zero_wait", 32'(ctl), 32'(C_BRQ));
        tick();
        check("br_cnt", 32'(stall_cnt_o), 6);
        mem_ack_i = 1'b0;
        #1 check("frz_over_br", 32'(ctl), 32'(C_FRZ));
        tick();
        mem_ack_i = 1'b1;
        #1 check("frz_br_ack", 32'(ctl), 32'(C_REQ));
        tick();
        idle();
        #1 check("frz_br_cnt", 32'(stall_cnt_o), 7);

        // Saturation: 10 more load-use cycles from 7 clamp at 15
        set_lu(5'd5, 5'd5, 5'd5);
        for (int i = 0; i < 10; i++) tick();
        idle();
        #1 check("sat_cnt", 32'(stall_cnt_o), 15);

        // Timeout: one RUN freeze, WAIT wcnt 1..3 frozen, wcnt 4 abandons
        EXMEM_MemRead_i = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) begin
            #1 check($sformatf("to_frz%0d", i), 32'(ctl), 32'(C_FRZ));
            tick();
        end
        #1 check("to_release", 32'(ctl), 32'(C_DEF));
        check("to_err_before", 32'(err_o), 0);
        tick();
        idle();
        #1 check("to_err", 32'(err_o), 1);
        check("to_run_ctl", 32'(ctl), 32'(C_DEF));
        check("to_sat_hold", 32'(stall_cnt_o), 15);
        EXMEM_Branch_i  = 1'b1;
        EXMEM_ALUzero_i = 1'b1;
        #1 check("to_state_run", 32'(ctl), 32'(C_BR));
        tick();
        idle();
        #1 check("err_sticky", 32'(err_o), 1);

        // One-cycle reset clears counter and flag
        rst_i = 1'b1;
        #1 check("rst_ctl", 32'(ctl), 32'(C_DEF));
        tick();
        rst_i = 1'b0;
        #1 check("rst_err", 32'(err_o), 0);
        check("rst_cnt", 32'(stall_cnt_o), 0);

        // Reset in the middle of WAIT
        EXMEM_MemRead_i = 1'b1;
        #1 check("mw_frz", 32'(ctl), 32'(C_FRZ));
        tick();
        #1 check("mw_wait", 32'(ctl), 32'(C_FRZ));
        rst_i = 1'b1;
        #1 check("mw_rst_req", 32'(mem_req_o), 0);
        check("mw_rst_ctl", 32'(ctl), 32'(C_DEF));
        tick();
        rst_i = 1'b0;
        idle();
        EXMEM_Branch_i  = 1'b1;
        EXMEM_ALUzero_i = 1'b1;
        #1 check("mw_state_run", 32'(ctl), 32'(C_BR));
        check("mw_cnt", 32'(stall_cnt_o), 0);
        tick();
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Drives write-enable, hold and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and resolves taken branches from the EX/MEM stage.
- Runs a req/ack handshake with a variable-latency data memory, freezing the pipeline until the access completes.
- Keeps a stall-cycle performance counter and a sticky memory-timeout error flag.

Parameters:
- TIMEOUT, 255: maximum WAIT cycles without mem_ack_i before the access is abandoned.
- CNT_W, 16: width of the stall_cnt_o counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- IDEX_MemRead_i  input  1  the instruction in ID/EX is a load.
- IDEX_RegRt_i  input  5  load destination register in ID/EX.
- IFID_RegRs_i  input  5  rs field of the instruction in IF/ID.
- IFID_RegRt_i  input  5  rt field of the instruction in IF/ID.
- EXMEM_Branch_i  input  1  the EX/MEM instruction is a branch.
- EXMEM_ALUzero_i  input  1  ALU zero flag in EX/MEM.
- EXMEM_MemRead_i  input  1  the EX/MEM instruction reads data memory.
- EXMEM_MemWrite_i  input  1  the EX/MEM instruction writes data memory.
- mem_ack_i  input  1  data-memory completion pulse.
- PCWrite_o  output  1  PC load enable.
- PCSrc_o  output  1  1 selects the branch target (EX/MEM Adderdata).
- IFIDWrite_o  output  1  IF/ID load enable.
- IFIDFlush_o  output  1  load a bubble into IF/ID.
- IDEXWrite_o  output  1  ID/EX load enable.
- IDEXFlush_o  output  1  load a bubble (all controls 0) into ID/EX.
- EXMEMWrite_o  output  1  EX/MEM load enable.
- EXMEMFlush_o  output  1  load a bubble into EX/MEM.
- MEMWBBubble_o  output  1  load a bubble into MEM/WB.
- mem_req_o  output  1  data-memory request.
- stall_cnt_o  output  CNT_W  saturating count of stalled cycles.
- err_o  output  1  sticky timeout flag.

Behaviour:
- State register: RUN or WAIT. A wait counter wcnt is 8 bits minimum, sized for TIMEOUT.
- Reset (rst_i high at an edge):
  - state=RUN, wcnt=0, stall_cnt_o=0, err_o=0.
  - While rst_i is high, combinational outputs are forced: all *Write_o=1, all flush/bubble outputs=0, PCSrc_o=0, mem_req_o=0.
- Default (no event): all *Write_o=1, flushes=0, PCSrc_o=0, mem_req_o=0.
- memop = EXMEM_MemRead_i | EXMEM_MemWrite_i.
- RUN, memop=1:
  - mem_req_o=1 combinationally.
  - mem_ack_i=1 in the same cycle: zero-wait access, no freeze, stay RUN.
  - Otherwise freeze this cycle and go to WAIT with wcnt=1.
- Freeze means: PCWrite_o=IFIDWrite_o=IDEXWrite_o=EXMEMWrite_o=0 and MEMWBBubble_o=1.
- WAIT:
  - mem_req_o=1 and freeze held every cycle.
  - mem_ack_i=1: freeze released in that same cycle (all write enables 1, MEMWBBubble_o=0) and next state=RUN.
  - No ack: wcnt increments.
  - No ack and wcnt==TIMEOUT: err_o set (sticky until reset), freeze released that cycle, mem_req_o=0, next state=RUN.
- Branch taken (state RUN, EXMEM_Branch_i & EXMEM_ALUzero_i):
  - PCSrc_o=1, IFIDFlush_o=1, IDEXFlush_o=1, EXMEMFlush_o=1 for one cycle.
  - No stall is applied.
- Load-use (state RUN, no branch taken, no freeze):
  - Condition: IDEX_MemRead_i & IDEX_RegRt_i!=0 & (IDEX_RegRt_i==IFID_RegRs_i | IDEX_RegRt_i==IFID_RegRt_i).
  - Response: PCWrite_o=0, IFIDWrite_o=0, IDEXFlush_o=1 for one cycle. Re-evaluated every cycle.
- Priority: memory freeze > branch flush > load-use.
  - A branch or load-use condition present during a freeze is not acted on. It is re-evaluated after release, because the registers held their contents.
- stall_cnt_o increments by 1 in every cycle where freeze or load-use stall is asserted, and saturates at all-ones.
- mem_ack_i in RUN with memop=0 is ignored.
- Reset asserted during WAIT: mem_req_o drops in the same cycle, and the state is RUN after the edge.

Test Plan:
- Load-use: IDEX_MemRead_i=1, IDEX_RegRt_i=8, IFID_RegRs_i=8 -> exactly one cycle of PCWrite_o=0, IFIDWrite_o=0, IDEXFlush_o=1; stall_cnt_o=1.
- Load-use suppressed for $zero: IDEX_RegRt_i=0, IFID_RegRt_i=0 -> no stall; IDEX_RegRt_i=8 with IFID_RegRs_i/IFID_RegRt_i=9,10 -> no stall.
- Zero-wait memory: EXMEM_MemRead_i=1 with mem_ack_i=1 in the same cycle -> mem_req_o=1 for 1 cycle, no freeze, stall_cnt_o unchanged.
- 3-cycle memory: EXMEM_MemWrite_i=1, ack 3 cycles after request -> mem_req_o high 4 cycles, freeze for the first 3, released in the ack cycle, stall_cnt_o=3.
- Branch taken: EXMEM_Branch_i=1, EXMEM_ALUzero_i=1 -> PCSrc_o=1 and all three flushes for 1 cycle. Same with ALUzero=0 -> no action.
- Timeout and reset:
  - TIMEOUT=4 with no ack -> err_o=1 after 4 WAIT cycles, req dropped, state RUN.
  - Then rst_i for 1 cycle -> err_o=0, stall_cnt_o=0.
  - rst_i asserted mid-WAIT -> mem_req_o=0 immediately.
